// File: rtl/count_capture.sv
// Event recorder for an upstream 8-bit counter: overflow pulses and capture strobes
// become tagged records queued in a small FIFO, with a saturating count of lost records.
module count_capture #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               count,
  input  logic                     overflow,
  input  logic                     capture,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drops
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [5:0]    wrap_cnt;
  logic [5:0]    wrap_next;
  logic          evt;
  logic          full;
  logic          pop;
  logic          push;
  logic [DW-1:0] record;
  logic [AW:0]   level_next;

  assign evt       = overflow | capture;
  assign wrap_next = wrap_cnt + {5'd0, overflow};
  assign record    = {overflow, capture, wrap_next, count};
  assign full      = (level == FULL_LVL);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the event.
  assign push      = evt & (~full | pop);

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + (AW+1)'(1);
      2'b01:   level_next = level - (AW+1)'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wrap_cnt  <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      drops     <= '0;
    end else begin
      wrap_cnt  <= wrap_next;
      level     <= level_next;
      out_valid <= (level_next != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (evt && !push && drops != 8'hff) drops <= drops + 8'd1;
    end
  end

  // Storage is deliberately left out of reset; out_valid guards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_count_capture.sv
// Randomized and directed bench for count_capture, checked against a queue-based model.
module tb_count_capture;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  count = '0;
  logic        overflow = 1'b0;
  logic        capture = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]  drops;

  int errors = 0;
  int checks = 0;

  logic [15:0] mq[$];
  int m_drops = 0;
  int m_wraps = 0;

  count_capture #(.DEPTH(DEPTH), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n), .count(count), .overflow(overflow),
    .capture(capture), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .drops(drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, int'(out_valid), (mq.size() != 0) ? 1 : 0);
    chk({tag, ".level"}, int'(level), mq.size());
    chk({tag, ".drops"}, int'(drops), m_drops);
    if (mq.size() != 0) chk({tag, ".data"}, int'(out_data), int'(mq[0]));
  endtask

  // One cycle: drive at negedge, advance the model at posedge, check at the next negedge.
  task automatic step(input string tag, input logic ov, input logic cap,
                      input logic rdy, input logic [7:0] cnt);
    bit did_pop;
    logic [15:0] rec;
    overflow = ov; capture = cap; out_ready = rdy; count = cnt;
    @(posedge clk);
    did_pop = (mq.size() != 0) && rdy;
    if (ov) m_wraps = (m_wraps + 1) % 64;
    rec = {ov, cap, 6'(m_wraps), cnt};
    if (did_pop) void'(mq.pop_front());
    if (ov || cap) begin
      if (mq.size() < DEPTH) mq.push_back(rec);
      else if (m_drops < 255) m_drops++;
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset(input bit check_async);
    overflow = 0; capture = 0; out_ready = 0;
    #2 reset_n = 1'b0;
    #1;
    if (check_async) begin
      chk("rst_async.valid", int'(out_valid), 0);
      chk("rst_async.level", int'(level), 0);
      chk("rst_async.drops", int'(drops), 0);
    end
    mq.delete(); m_drops = 0; m_wraps = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b0);
    @(negedge clk);
    check_state("post_reset");

    // Single capture popped immediately.
    step("cap2a", 0, 1, 1, 8'h2a);
    chk("cap2a.const", int'(out_data), 16'h402a);
    step("cap2a_pop", 0, 0, 1, 8'h00);
    chk("cap2a.level0", int'(level), 0);

    // Overflow and capture together on the first wrap.
    step("ovcap", 1, 1, 0, 8'h00);
    chk("ovcap.const", int'(out_data), 16'hc100);
    chk("ovcap.level1", int'(level), 1);
    step("ovcap_pop", 0, 0, 1, 8'h00);

    // Fill past DEPTH with the consumer stalled.
    for (int i = 1; i <= 6; i++) step("fill", 0, 1, 0, 8'(i));
    chk("fill.level4", int'(level), 4);
    chk("fill.drops2", int'(drops), 2);
    for (int i = 1; i <= 4; i++) begin
      chk("drain.order", int'(out_data), 16'h4100 | i);
      step("drain", 0, 0, 1, 8'h00);
    end

    // Full FIFO: simultaneous push and pop.
    for (int i = 0; i < 4; i++) step("refill", 0, 1, 0, 8'h10 + 8'(i));
    step("full_pushpop", 0, 1, 1, 8'h77);
    chk("full_pushpop.level", int'(level), 4);
    chk("full_pushpop.drops", int'(drops), 2);
    for (int i = 0; i < 3; i++) step("tail", 0, 0, 1, 8'h00);
    chk("tail.last", int'(out_data), 16'h4177);
    step("tail_end", 0, 0, 1, 8'h00);

    // Wrap counter modulo 64.
    do_reset(1'b0);
    @(negedge clk);
    check_state("reset2");
    for (int i = 1; i <= 65; i++) begin
      step("wrap", 1, 0, 1, 8'h00);
      if (i == 64) chk("wrap64", int'(out_data[13:8]), 0);
      if (i == 65) chk("wrap65", int'(out_data[13:8]), 1);
    end

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom));
    end
    for (int i = 0; i < 400; i++) begin
      step("rand_burst", ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    // Asynchronous reset with queued records.
    for (int i = 0; i < 3; i++) step("preq", 0, 1, 0, 8'h50 + 8'(i));
    do_reset(1'b1);
    @(negedge clk);
    check_state("after_rst");
    step("after_rst_cap", 0, 1, 0, 8'h33);
    chk("after_rst_cap.const", int'(out_data), 16'h4033);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
